// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock enable, coordinates, blanking and syncs, NTSC/PAL and 31 kHz scandoubled.
// Define VIDEO_TIMING_INTERLACE_EN to enable field toggling and the odd-field extra line / half-line VSync.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE  = 320,
  parameter int unsigned H_FP      = 8,
  parameter int unsigned H_SYNC    = 32,
  parameter int unsigned H_BP      = 40,
  parameter int unsigned V_ACTIVE  = 240,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_FP_NTSC = 4,
  parameter int unsigned V_BP_NTSC = 14,
  parameter int unsigned V_FP_PAL  = 27,
  parameter int unsigned V_BP_PAL  = 41
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pal,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic       frame_start,
  output logic       field
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] HA      = 9'(H_ACTIVE);
  localparam logic [8:0] HS_BEG  = 9'(H_ACTIVE + H_FP);
  localparam logic [8:0] HS_END  = 9'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VT_NTSC = 10'(V_ACTIVE + V_FP_NTSC + V_SYNC + V_BP_NTSC);
  localparam logic [9:0] VT_PAL  = 10'(V_ACTIVE + V_FP_PAL + V_SYNC + V_BP_PAL);
  localparam logic [8:0] VA      = 9'(V_ACTIVE);
  localparam logic [8:0] VS_NTSC = 9'(V_ACTIVE + V_FP_NTSC);
  localparam logic [8:0] VS_PAL  = 9'(V_ACTIVE + V_FP_PAL);
  localparam logic [8:0] VSW     = 9'(V_SYNC);
`ifdef VIDEO_TIMING_INTERLACE_EN
  localparam logic [8:0] H_HALF  = 9'(H_TOTAL / 2);
`endif

  logic [1:0] div;
  logic [8:0] h_pos;      // pixel presented at the next ce
  logic [9:0] line_pos;   // physical line, doubled range in scandouble
  logic       pal_s, sd_s, field_q;

  logic       tick, h_wrap, l_wrap, vsync_cur;
  logic [9:0] v_total, line_last;
  logic [8:0] v_cur, vs_beg;

  always_comb begin
    tick    = sd_s ? ~div[0] : (div == 2'd2);
    v_total = pal_s ? VT_PAL : VT_NTSC;
`ifdef VIDEO_TIMING_INTERLACE_EN
    if (field_q && !sd_s) v_total = v_total + 10'd1;
`endif
    line_last = sd_s ? ({v_total[8:0], 1'b0} - 10'd1) : (v_total - 10'd1);
    v_cur     = sd_s ? line_pos[9:1] : line_pos[8:0];
    vs_beg    = pal_s ? VS_PAL : VS_NTSC;
    h_wrap    = (h_pos == H_LAST);
    l_wrap    = (line_pos == line_last);
    vsync_cur = (v_cur >= vs_beg) && (v_cur < vs_beg + VSW);
`ifdef VIDEO_TIMING_INTERLACE_EN
    // Odd field starts VSync half-way through its first sync line
    if (field_q && !sd_s && (v_cur == vs_beg) && (h_pos < H_HALF)) vsync_cur = 1'b0;
`endif
  end

  // Outputs are loaded from the pending position on the edge that raises ce_pix,
  // so they describe the current pixel exactly while ce_pix is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      h_pos       <= '0;
      line_pos    <= '0;
      field_q     <= 1'b0;
      pal_s       <= pal;
      sd_s        <= scandouble;
      ce_pix      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      HBlank      <= 1'b0;
      HSync       <= 1'b0;
      VBlank      <= 1'b0;
      VSync       <= 1'b0;
      frame_start <= 1'b0;
      field       <= 1'b0;
    end else begin
      div         <= div + 2'd1;
      ce_pix      <= tick;
      frame_start <= 1'b0;
      if (tick) begin
        hcount      <= h_pos;
        vcount      <= v_cur;
        HBlank      <= (h_pos >= HA);
        HSync       <= (h_pos >= HS_BEG) && (h_pos < HS_END);
        VBlank      <= (v_cur >= VA);
        VSync       <= vsync_cur;
        field       <= field_q;
        frame_start <= (h_pos == '0) && (line_pos == '0);
        if (h_wrap) begin
          h_pos <= '0;
          if (l_wrap) begin
            line_pos <= '0;
            pal_s    <= pal;
            sd_s     <= scandouble;
`ifdef VIDEO_TIMING_INTERLACE_EN
            field_q  <= ~field_q;
`endif
          end else begin
            line_pos <= line_pos + 10'd1;
          end
        end else begin
          h_pos <= h_pos + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a reduced-size instance for full-frame behaviour and a default-size instance for line timing.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Reduced raster: H 16+2+4+6 = 28, V NTSC 10+1+2+3 = 16, PAL 10+3+2+5 = 20
  localparam int SH      = 28;
  localparam int SH_HALF = 14;

  logic       s_rst, s_pal, s_sd, s_ce, s_hb, s_hs, s_vb, s_vs, s_fs, s_fld;
  logic [8:0] s_hc, s_vc;
  logic       f_rst, f_pal, f_sd, f_ce, f_hb, f_hs, f_vb, f_vs, f_fs, f_fld;
  logic [8:0] f_hc, f_vc;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(6),
    .V_ACTIVE(10), .V_SYNC(2),
    .V_FP_NTSC(1), .V_BP_NTSC(3), .V_FP_PAL(3), .V_BP_PAL(5)
  ) u_small (
    .clk(clk), .reset(s_rst), .pal(s_pal), .scandouble(s_sd),
    .ce_pix(s_ce), .hcount(s_hc), .vcount(s_vc),
    .HBlank(s_hb), .HSync(s_hs), .VBlank(s_vb), .VSync(s_vs),
    .frame_start(s_fs), .field(s_fld)
  );

  video_timing_gen u_full (
    .clk(clk), .reset(f_rst), .pal(f_pal), .scandouble(f_sd),
    .ce_pix(f_ce), .hcount(f_hc), .vcount(f_vc),
    .HBlank(f_hb), .HSync(f_hs), .VBlank(f_vb), .VSync(f_vs),
    .frame_start(f_fs), .field(f_fld)
  );

  int checks = 0;
  int errors = 0;
  int ef     = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ce(input bit full, output int gap);
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while (!(full ? f_ce : s_ce) && gap < 64);
    if (!(full ? f_ce : s_ce)) check("ce_timeout", gap, 0);
  endtask

  task automatic toggle_field();
`ifdef VIDEO_TIMING_INTERLACE_EN
    ef = 1 - ef;
`endif
  endtask

  // Entered while the (0,0) pixel is presented; walks to the next frame_start.
  // act_kind: 1 pal=1, 2 sd=1, 3 pal=0, 4 sd=0, applied at line act_line.
  task automatic run_frame(input int pal_m, input int sd_m, input int fld,
                           input int act_line, input int act_kind, input int stop_line);
    int rep, lines, vs_lo, gap, gmin, gmax, ces, phys, exp_h, bad_h, v;
    logic exp_hb, exp_hs, exp_vs;
    rep   = sd_m ? 2 : 1;
    lines = (pal_m ? 20 : 16) * rep + ((fld != 0 && sd_m == 0) ? 1 : 0);
    vs_lo = pal_m ? 13 : 11;
    gmin  = 99; gmax = 0; ces = 1; phys = 0; exp_h = 0; bad_h = 0;
    check("field", int'(s_fld), fld);
    while (1) begin
      exp_hb = (exp_h >= 16);
      exp_hs = (exp_h >= 18 && exp_h <= 21);
      if (int'(s_hc) != exp_h || s_hb != exp_hb || s_hs != exp_hs) bad_h++;
      if (exp_h == 0) begin
        v      = phys / rep;
        exp_vs = (v >= vs_lo && v < vs_lo + 2) && !(fld != 0 && sd_m == 0 && v == vs_lo);
        check("vcount", int'(s_vc), v);
        check("vblank", int'(s_vb), (v >= 10) ? 1 : 0);
        check("vsync", int'(s_vs), int'(exp_vs));
        if (phys == act_line) begin
          case (act_kind)
            1: s_pal = 1'b1;
            2: s_sd  = 1'b1;
            3: s_pal = 1'b0;
            4: s_sd  = 1'b0;
            default: ;
          endcase
        end
      end
      if (fld != 0 && sd_m == 0 && phys == vs_lo && exp_h == SH_HALF)
        check("vsync_half_line", int'(s_vs), 1);
      if (phys == stop_line && exp_h == 9) return;
      wait_ce(1'b0, gap);
      if (s_fs) break;
      if (ces > 1) begin
        if (gap < gmin) gmin = gap;
        if (gap > gmax) gmax = gap;
      end
      ces++;
      exp_h++;
      if (exp_h == SH) begin
        exp_h = 0;
        phys++;
      end
      if (ces > 3000) begin
        check("frame_runaway", ces, lines * SH);
        return;
      end
    end
    check("frame_pixels", ces, lines * SH);
    check("ce_gap_min", gmin, sd_m ? 2 : 4);
    check("ce_gap_max", gmax, sd_m ? 2 : 4);
    check("hdecode_bad", bad_h, 0);
    check("next_frame_h", int'(s_hc), 0);
    check("next_frame_v", int'(s_vc), 0);
  endtask

  initial begin
    int gap, clks, first_hb, first_hs, last_hs, bad, gmin, gmax;
    s_rst = 1'b1; s_pal = 1'b0; s_sd = 1'b0;
    f_rst = 1'b1; f_pal = 1'b0; f_sd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", int'({s_ce, s_hb, s_hs, s_vb, s_vs, s_fs, s_fld}), 0);
    check("rst_hcount", int'(s_hc), 0);
    check("rst_vcount", int'(s_vc), 0);

    // Divider leaves reset at 0, so ce first rises with divider 3
    s_rst = 1'b0;
    wait_ce(1'b0, gap);
    check("first_ce_gap", gap, 3);
    check("first_fs", int'(s_fs), 1);
    check("first_h", int'(s_hc), 0);
    check("first_v", int'(s_vc), 0);
    check("first_flags", int'({s_hb, s_hs, s_vb, s_vs}), 0);
    @(posedge clk);
    #1;
    check("ce_drop", int'(s_ce), 0);
    check("fs_drop", int'(s_fs), 0);
    check("h_hold", int'(s_hc), 0);

    run_frame(0, 0, ef, 5, 1, -1); toggle_field();
    run_frame(1, 0, ef, 3, 2, -1); toggle_field();
    run_frame(1, 1, ef, 7, 3, -1); toggle_field();
    run_frame(0, 1, ef, 5, 4, -1); toggle_field();
    run_frame(0, 0, ef, -1, 0, 6);

    // One-clock reset pulse mid-frame
    s_rst = 1'b1;
    @(posedge clk);
    #1;
    s_rst = 1'b0;
    check("midrst_flags", int'({s_ce, s_hb, s_hs, s_vb, s_vs, s_fs, s_fld}), 0);
    check("midrst_h", int'(s_hc), 0);
    check("midrst_v", int'(s_vc), 0);
    ef = 0;
    wait_ce(1'b0, gap);
    check("midrst_gap", gap, 3);
    check("midrst_fs", int'(s_fs), 1);
    check("midrst_origin", int'(s_hc) + int'(s_vc), 0);
    run_frame(0, 0, ef, -1, 0, -1); toggle_field();
    run_frame(0, 0, ef, -1, 0, -1);

    // Default geometry: one full NTSC line
    f_rst = 1'b0;
    wait_ce(1'b1, gap);
    check("full_first_gap", gap, 3);
    check("full_fs", int'(f_fs), 1);
    check("full_origin", int'(f_hc) + int'(f_vc), 0);
    clks = 0; first_hb = -1; first_hs = -1; last_hs = -1; bad = 0; gmin = 99; gmax = 0;
    for (int k = 1; k < 400; k++) begin
      wait_ce(1'b1, gap);
      clks += gap;
      if (gap < gmin) gmin = gap;
      if (gap > gmax) gmax = gap;
      if (int'(f_hc) != k || f_vc != 9'd0 || f_fs || f_vb || f_vs) bad++;
      if (f_hb && first_hb < 0) first_hb = k;
      if (f_hs && first_hs < 0) first_hs = k;
      if (f_hs) last_hs = k;
    end
    check("full_line_bad", bad, 0);
    check("full_hblank_start", first_hb, 320);
    check("full_hsync_start", first_hs, 328);
    check("full_hsync_end", last_hs, 359);
    check("full_gap_min", gmin, 4);
    check("full_gap_max", gmax, 4);
    wait_ce(1'b1, gap);
    clks += gap;
    check("full_line_clks", clks, 1600);
    check("full_l1_h", int'(f_hc), 0);
    check("full_l1_v", int'(f_vc), 1);
    check("full_l1_flags", int'({f_fs, f_hb, f_hs, f_vb, f_vs}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
